shadow_config_mem: RTL and testbench

Clocked, double-buffered successor to the latch-based tile configuration memory.
Frames written via FrameData/FrameStrobe land in a shadow store. They reach ConfigBits only on an explicit Commit, giving atomic, glitch-free reconfiguration of a tile.
Adds multi-frame support, frame readback and a commit counter. Instantiated once per tile, between the column frame bus and the tile switch matrix and BELs.

---
 rtl/shadow_config_mem_pkg.sv | 20 ++
 rtl/shadow_config_mem_frame.sv | 27 ++
 rtl/shadow_config_mem.sv | 130 +++++++++++++
 tb/tb_shadow_config_mem.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shadow_config_mem_pkg.sv
// Shared definitions for the double-buffered tile configuration memory.
// Frame index sizing, readback source codes and bit mapping helper.
package shadow_config_mem_pkg;

  localparam logic SRC_SHADOW = 1'b0;
  localparam logic SRC_ACTIVE = 1'b1;

  function automatic int fIdxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cfgIdx(
    input int f,
    input int b,
    input int w
  );
    return f * w + b;
  endfunction

endpackage

// File: rtl/shadow_config_mem_frame.sv
// One configuration frame: shadow register written from the frame bus,
// active register loaded from shadow on commit.
module config_frame_reg #(
  parameter int             W    = 32,
  parameter logic [W-1:0]   Init = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         wrEn,
  input  logic         commitEn,
  input  logic [W-1:0] wrData,
  output logic [W-1:0] shadow,
  output logic [W-1:0] active
);

  // Commit copies the pre-edge shadow, so a same-cycle write lands in shadow only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow <= Init;
      active <= Init;
    end else begin
      if (wrEn)     shadow <= wrData;
      if (commitEn) active <= shadow;
    end
  end

endmodule

// File: rtl/shadow_config_mem.sv
// Double-buffered tile configuration memory with atomic commit,
// frame readback, dirty tracking and a wrapping commit counter.
module shadow_config_mem
  import shadow_config_mem_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NoFrames        = 2,
  parameter int NoConfigBits    = 40,
  parameter int CntWidth        = 8
`ifdef EMULATION
  ,
  parameter logic [NoFrames*FrameBitsPerRow-1:0] Emulate_Bitstream = '0
`endif
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [FrameBitsPerRow-1:0]    FrameData,
  input  logic [MaxFramesPerCol-1:0]    FrameStrobe,
  input  logic                          Commit,
  input  logic                          ReadEn,
  input  logic [fIdxW(NoFrames)-1:0]    ReadSel,
  input  logic                          ReadSrc,
  output logic [NoConfigBits-1:0]       ConfigBits,
  output logic [NoConfigBits-1:0]       ConfigBits_N,
  output logic [FrameBitsPerRow-1:0]    ReadData,
  output logic                          ReadValid,
  output logic                          ReadErr,
  output logic                          Dirty,
  output logic [CntWidth-1:0]           CommitCnt
);

  localparam int SelW = fIdxW(NoFrames);
  localparam int NSel = 1 << SelW;
  localparam int AW   = NoFrames * FrameBitsPerRow;
  localparam logic [SelW:0] NFr = (SelW + 1)'(NoFrames);

  logic [FrameBitsPerRow-1:0] shadowArr [NSel];
  logic [FrameBitsPerRow-1:0] activeArr [NSel];
  logic [AW-1:0]              activeFlat;
  logic [NoFrames-1:0]        wrEn;
  logic                       anyWr;
  logic                       inRange;
  logic [FrameBitsPerRow-1:0] rdSrcData;
  logic                       unusedStrb;
  logic                       unusedAct;

  assign wrEn  = FrameStrobe[NoFrames-1:0];
  assign anyWr = |wrEn;

  assign unusedStrb = ^FrameStrobe;
  assign unusedAct  = ^activeFlat;

  for (genvar f = 0; f < NSel; f++) begin : gFrame
    if (f < NoFrames) begin : gReg
`ifdef EMULATION
      localparam logic [FrameBitsPerRow-1:0] InitVal =
        Emulate_Bitstream[cfgIdx(f, 0, FrameBitsPerRow) +: FrameBitsPerRow];
`else
      localparam logic [FrameBitsPerRow-1:0] InitVal = '0;
`endif
      config_frame_reg #(
        .W    (FrameBitsPerRow),
        .Init (InitVal)
      ) uFrame (
        .CLK      (CLK),
        .RST      (RST),
        .wrEn     (wrEn[f]),
        .commitEn (Commit),
        .wrData   (FrameData),
        .shadow   (shadowArr[f]),
        .active   (activeArr[f])
      );
      assign activeFlat[cfgIdx(f, 0, FrameBitsPerRow) +: FrameBitsPerRow] =
        activeArr[f];
    end else begin : gPad
      assign shadowArr[f] = '0;
      assign activeArr[f] = '0;
    end
  end

  assign ConfigBits   = activeFlat[NoConfigBits-1:0];
  assign ConfigBits_N = ~activeFlat[NoConfigBits-1:0];

  assign inRange   = {1'b0, ReadSel} < NFr;
  assign rdSrcData = (ReadSrc == SRC_ACTIVE) ? activeArr[ReadSel]
                                             : shadowArr[ReadSel];

  // Registered readback: one-cycle latency, pulses for valid/error, data holds.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ReadData  <= '0;
      ReadValid <= 1'b0;
      ReadErr   <= 1'b0;
    end else begin
      ReadValid <= 1'b0;
      ReadErr   <= 1'b0;
      if (ReadEn) begin
        if (inRange) begin
          ReadData  <= rdSrcData;
          ReadValid <= 1'b1;
        end else begin
          ReadData  <= '0;
          ReadErr   <= 1'b1;
        end
      end
    end
  end

  // A write wins over a same-cycle commit so new shadow data is never lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Dirty <= 1'b0;
    end else if (anyWr) begin
      Dirty <= 1'b1;
    end else if (Commit) begin
      Dirty <= 1'b0;
    end
  end

  // Commit counter, free-running wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CommitCnt <= '0;
    end else if (Commit) begin
      CommitCnt <= CommitCnt + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_shadow_config_mem.sv
// Directed bench for shadow_config_mem: default instance plus a
// three-frame instance for out-of-range readback.
module tb_shadow_config_mem;

  logic        CLK;
  logic        RST;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        Commit;
  logic        ReadEn;
  logic        ReadSel;
  logic [1:0]  ReadSel3;
  logic        ReadSrc;

  logic [39:0] ConfigBits, ConfigBits_N;
  logic [31:0] ReadData;
  logic        ReadValid, ReadErr, Dirty;
  logic [7:0]  CommitCnt;

  logic [39:0] cb3, cbn3;
  logic [31:0] rd3;
  logic        rv3, re3, dirty3;
  logic [7:0]  cnt3;

  int nCmp = 0;
  int nBad = 0;
  logic [7:0] expCnt = 8'd0;

  shadow_config_mem dut (
    .CLK          (CLK),
    .RST          (RST),
    .FrameData    (FrameData),
    .FrameStrobe  (FrameStrobe),
    .Commit       (Commit),
    .ReadEn       (ReadEn),
    .ReadSel      (ReadSel),
    .ReadSrc      (ReadSrc),
    .ConfigBits   (ConfigBits),
    .ConfigBits_N (ConfigBits_N),
    .ReadData     (ReadData),
    .ReadValid    (ReadValid),
    .ReadErr      (ReadErr),
    .Dirty        (Dirty),
    .CommitCnt    (CommitCnt)
  );

  shadow_config_mem #(.NoFrames(3)) dut3 (
    .CLK          (CLK),
    .RST          (RST),
    .FrameData    (FrameData),
    .FrameStrobe  (FrameStrobe),
    .Commit       (Commit),
    .ReadEn       (ReadEn),
    .ReadSel      (ReadSel3),
    .ReadSrc      (ReadSrc),
    .ConfigBits   (cb3),
    .ConfigBits_N (cbn3),
    .ReadData     (rd3),
    .ReadValid    (rv3),
    .ReadErr      (re3),
    .Dirty        (dirty3),
    .CommitCnt    (cnt3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [19:0] strb, input logic [31:0] d);
    FrameStrobe = strb;
    FrameData   = d;
    tick();
    FrameStrobe = '0;
  endtask

  task automatic cmt();
    Commit = 1'b1;
    tick();
    Commit = 1'b0;
    expCnt = expCnt + 8'd1;
  endtask

  task automatic rd(input logic sel, input logic src);
    ReadEn  = 1'b1;
    ReadSel = sel;
    ReadSrc = src;
    tick();
    ReadEn  = 1'b0;
  endtask

  task automatic midReset();
    #3 RST = 1'b1;
    #1;
  endtask

  initial begin
    RST = 1'b1; FrameData = '0; FrameStrobe = '0; Commit = 1'b0;
    ReadEn = 1'b0; ReadSel = 1'b0; ReadSel3 = 2'd0; ReadSrc = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    chk("rst_cfg",   {24'h0, ConfigBits},   64'h0);
    chk("rst_cfgn",  {24'h0, ConfigBits_N}, 64'hFF_FFFF_FFFF);
    chk("rst_rdata", {32'h0, ReadData},     64'h0);
    chk("rst_flags", {61'h0, ReadValid, ReadErr, Dirty}, 64'h0);
    chk("rst_cnt",   {56'h0, CommitCnt},    64'h0);

    // load something, then assert reset asynchronously mid-cycle
    wr(20'h1, 32'hCAFEF00D);
    cmt();
    chk("pre_cfg", {24'h0, ConfigBits}, 64'h00_CAFEF00D);
    chk("pre_cnt", {56'h0, CommitCnt},  64'h1);
    wr(20'h2, 32'h0BADF00D);
    rd(1'b1, 1'b0);
    chk("pre_rv", {63'h0, ReadValid}, 64'h1);
    midReset();
    chk("arst_cfg",   {24'h0, ConfigBits},   64'h0);
    chk("arst_cfgn",  {24'h0, ConfigBits_N}, 64'hFF_FFFF_FFFF);
    chk("arst_dirty", {63'h0, Dirty},        64'h0);
    chk("arst_cnt",   {56'h0, CommitCnt},    64'h0);
    chk("arst_rd",    {31'h0, ReadValid, ReadData}, 64'h0);
    #1 RST = 1'b0;
    expCnt = 8'd0;
    tick();

    // shadow isolation
    wr(20'h1, 32'hDEADBEEF);
    chk("iso_cfg",   {24'h0, ConfigBits}, 64'h0);
    chk("iso_dirty", {63'h0, Dirty},      64'h1);
    cmt();
    chk("iso_cfg2",  {24'h0, ConfigBits}, 64'h00_DEADBEEF);
    chk("iso_dirty2",{63'h0, Dirty},      64'h0);
    chk("iso_cnt",   {56'h0, CommitCnt},  64'h1);

    // frame1 maps to bits 39:32, upper bytes truncated
    wr(20'h2, 32'h123456AB);
    cmt();
    chk("map_cfg",  {24'h0, ConfigBits},   64'hAB_DEADBEEF);
    chk("map_cfgn", {24'h0, ConfigBits_N}, 64'h54_21524110);

    // simultaneous write and commit
    wr(20'h1, 32'h11111111);
    FrameStrobe = 20'h1;
    FrameData   = 32'h22222222;
    cmt();
    FrameStrobe = '0;
    chk("sim_cfg",   {24'h0, ConfigBits}, 64'hAB_11111111);
    chk("sim_dirty", {63'h0, Dirty},      64'h1);
    cmt();
    chk("sim_cfg2",  {24'h0, ConfigBits}, 64'hAB_22222222);
    chk("sim_dirty2",{63'h0, Dirty},      64'h0);
    chk("sim_cnt",   {56'h0, CommitCnt},  {56'h0, expCnt});

    // readback
    wr(20'h1, 32'h33333333);
    ReadSel3 = 2'd0;
    rd(1'b0, 1'b0);
    chk("rb_sh0",  {32'h0, ReadData},  64'h33333333);
    chk("rb_vld",  {62'h0, ReadValid, ReadErr}, 64'h2);
    chk("rb3_sh0", {32'h0, rd3},       64'h33333333);
    tick();
    chk("rb_pulse",{63'h0, ReadValid}, 64'h0);
    chk("rb_hold", {32'h0, ReadData},  64'h33333333);
    rd(1'b0, 1'b1);
    chk("rb_act0", {32'h0, ReadData},  64'h22222222);
    ReadEn = 1'b1; ReadSel = 1'b1; ReadSrc = 1'b0;
    tick();
    chk("rb_b2b1", {31'h0, ReadValid, ReadData}, {31'h0, 1'b1, 32'h123456AB});
    ReadSrc = 1'b1;
    FrameStrobe = 20'h2; FrameData = 32'h77777777;
    tick();
    FrameStrobe = '0;
    chk("rb_b2b2", {31'h0, ReadValid, ReadData}, {31'h0, 1'b1, 32'h123456AB});
    ReadSrc = 1'b0;
    tick();
    ReadEn = 1'b0;
    chk("rb_b2b3", {32'h0, ReadData},  64'h77777777);

    // read in same cycle as write, then as commit
    FrameStrobe = 20'h1; FrameData = 32'h44444444;
    rd(1'b0, 1'b0);
    FrameStrobe = '0;
    chk("rb_wr_pre", {32'h0, ReadData}, 64'h33333333);
    ReadEn = 1'b1; ReadSel = 1'b0; ReadSrc = 1'b1;
    cmt();
    ReadEn = 1'b0;
    chk("rb_cm_pre", {32'h0, ReadData},  64'h22222222);
    chk("rb_cm_cfg", {24'h0, ConfigBits}, 64'h77_44444444);

    // out-of-range select on the three-frame instance
    ReadSel3 = 2'd3;
    rd(1'b0, 1'b0);
    chk("err_flag", {62'h0, re3, rv3}, 64'h2);
    chk("err_data", {32'h0, rd3},      64'h0);
    chk("err_none", {63'h0, ReadErr},  64'h0);
    tick();
    chk("err_pulse",{63'h0, re3},      64'h0);

    // ignored strobe bits
    wr(20'h80000, 32'hFFFFFFFF);
    wr(20'h00004, 32'hFFFFFFFF);
    chk("ign_dirty", {63'h0, Dirty},      64'h0);
    chk("ign_d3",    {63'h0, dirty3},     64'h1);
    chk("ign_cfg",   {24'h0, ConfigBits}, 64'h77_44444444);
    rd(1'b0, 1'b0);
    chk("ign_sh0",   {32'h0, ReadData},   64'h44444444);

    // multi-hot strobe
    wr(20'h3, 32'h5A5A5A5A);
    cmt();
    chk("multi_cfg", {24'h0, ConfigBits}, 64'h5A_5A5A5A5A);

    // counter wrap
    while (expCnt != 8'd255) cmt();
    chk("wrap_255", {56'h0, CommitCnt}, 64'hFF);
    cmt();
    chk("wrap_0",   {56'h0, CommitCnt}, 64'h0);
    chk("wrap_d3",  {56'h0, cnt3},      64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
